// File: rtl/decode_issue.sv
// decode_issue: one-entry decode register, RV32 subset decode,
// scoreboarded operand read and val/rdy micro-op issue.
module decode_issue #(
  parameter int          p_addr_bits = 32,
  parameter int          p_inst_bits = 32,
  parameter logic [31:0] p_rst_pc    = 32'b0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   F_val,
  output logic                   F_rdy,
  input  logic [p_inst_bits-1:0] F_inst,
  input  logic [p_addr_bits-1:0] F_pc,
  output logic                   F_squash,
  output logic [p_addr_bits-1:0] F_branch_target,
  output logic                   X_val,
  input  logic                   X_rdy,
  output logic [p_addr_bits-1:0] X_pc,
  output logic [3:0]             X_uop,
  output logic [p_inst_bits-1:0] X_op1,
  output logic [p_inst_bits-1:0] X_op2,
  output logic [p_inst_bits-1:0] X_imm,
  output logic [4:0]             X_waddr,
  output logic                   X_wen,
  input  logic                   W_val,
  input  logic [4:0]             W_waddr,
  input  logic [p_inst_bits-1:0] W_wdata
);

  typedef logic [p_inst_bits-1:0] t_data;
  typedef logic [p_addr_bits-1:0] t_addr;

  localparam logic [3:0] UOP_ADD  = 4'd0;
  localparam logic [3:0] UOP_ADDI = 4'd1;
  localparam logic [3:0] UOP_MUL  = 4'd2;
  localparam logic [3:0] UOP_LW   = 4'd3;
  localparam logic [3:0] UOP_SW   = 4'd4;
  localparam logic [3:0] UOP_JAL  = 4'd5;
  localparam logic [3:0] UOP_LUI  = 4'd6;
  localparam logic [3:0] UOP_ILL  = 4'd15;

  logic        r_dr_val;
  logic [31:0] r_dr_inst;
  t_addr       r_dr_pc;
  logic [31:0] r_pend;
  t_data       r_rf [32];

  logic [6:0]  w_opc;
  logic [2:0]  w_f3;
  logic [6:0]  w_f7;
  logic [4:0]  w_rd;
  logic [4:0]  w_rs1;
  logic [4:0]  w_rs2;
  logic        w_is_add;
  logic        w_is_mul;
  logic        w_is_addi;
  logic        w_is_lw;
  logic        w_is_sw;
  logic        w_is_jal;
  logic        w_is_lui;
  logic [3:0]  w_uop;
  logic        w_use1;
  logic        w_use2;
  logic        w_wr;
  logic        w_wen;
  t_data       w_imm;
  t_data       w_rs1_val;
  t_data       w_rs2_val;
  logic [20:0] w_jimm;
  logic [31:0] w_wclr;
  logic [31:0] w_pset;
  logic [31:0] w_pend_eff;
  logic        w_hz;
  logic        w_x_val;
  logic        w_x_xfer;
  logic        w_squash;
  logic        w_f_xfer;

  assign w_opc = r_dr_inst[6:0];
  assign w_rd  = r_dr_inst[11:7];
  assign w_f3  = r_dr_inst[14:12];
  assign w_rs1 = r_dr_inst[19:15];
  assign w_rs2 = r_dr_inst[24:20];
  assign w_f7  = r_dr_inst[31:25];

  assign w_is_add  = (w_opc == 7'h33) && (w_f3 == 3'd0)
                     && (w_f7 == 7'h00);
  assign w_is_mul  = (w_opc == 7'h33) && (w_f3 == 3'd0)
                     && (w_f7 == 7'h01);
  assign w_is_addi = (w_opc == 7'h13) && (w_f3 == 3'd0);
  assign w_is_lw   = (w_opc == 7'h03) && (w_f3 == 3'd2);
  assign w_is_sw   = (w_opc == 7'h23) && (w_f3 == 3'd2);
  assign w_is_jal  = (w_opc == 7'h6f);
  assign w_is_lui  = (w_opc == 7'h37);

  assign w_jimm = {r_dr_inst[31], r_dr_inst[19:12],
                   r_dr_inst[20], r_dr_inst[30:21], 1'b0};

  // Opcode decode: micro-op, register usage and immediate.
  always_comb begin
    w_uop  = UOP_ILL;
    w_use1 = 1'b0;
    w_use2 = 1'b0;
    w_wr   = 1'b0;
    w_imm  = '0;
    unique case (1'b1)
      w_is_add: begin
        w_uop  = UOP_ADD;
        w_use1 = 1'b1;
        w_use2 = 1'b1;
        w_wr   = 1'b1;
      end
      w_is_mul: begin
        w_uop  = UOP_MUL;
        w_use1 = 1'b1;
        w_use2 = 1'b1;
        w_wr   = 1'b1;
      end
      w_is_addi: begin
        w_uop  = UOP_ADDI;
        w_use1 = 1'b1;
        w_wr   = 1'b1;
        w_imm  = t_data'($signed(r_dr_inst[31:20]));
      end
      w_is_lw: begin
        w_uop  = UOP_LW;
        w_use1 = 1'b1;
        w_wr   = 1'b1;
        w_imm  = t_data'($signed(r_dr_inst[31:20]));
      end
      w_is_sw: begin
        w_uop  = UOP_SW;
        w_use1 = 1'b1;
        w_use2 = 1'b1;
        w_imm  = t_data'($signed({r_dr_inst[31:25],
                                  r_dr_inst[11:7]}));
      end
      w_is_jal: begin
        w_uop = UOP_JAL;
        w_wr  = 1'b1;
        w_imm = t_data'($signed(w_jimm));
      end
      w_is_lui: begin
        w_uop = UOP_LUI;
        w_wr  = 1'b1;
        w_imm = t_data'({r_dr_inst[31:12], 12'h000});
      end
      default: ;
    endcase
  end

  assign w_wen = w_wr && (w_rd != 5'd0);

  // Operand read with same-cycle writeback bypass; x0 reads zero.
  always_comb begin
    w_rs1_val = r_rf[w_rs1];
    w_rs2_val = r_rf[w_rs2];
    if (W_val && (W_waddr == w_rs1))
      w_rs1_val = W_wdata;
    if (W_val && (W_waddr == w_rs2))
      w_rs2_val = W_wdata;
    if (w_rs1 == 5'd0)
      w_rs1_val = '0;
    if (w_rs2 == 5'd0)
      w_rs2_val = '0;
  end

  assign w_wclr     = {31'b0, W_val} << W_waddr;
  assign w_pend_eff = r_pend & ~w_wclr;

  assign w_hz = r_dr_val &&
                ((w_use1 && w_pend_eff[w_rs1]) ||
                 (w_use2 && w_pend_eff[w_rs2]) ||
                 (w_wen  && w_pend_eff[w_rd]));

  assign w_x_val  = r_dr_val && !w_hz;
  assign w_x_xfer = w_x_val && X_rdy;
  assign w_squash = w_x_xfer && w_is_jal;
  assign w_f_xfer = F_val && F_rdy;
  assign w_pset   = {31'b0, w_x_xfer && w_wen} << w_rd;

  assign F_rdy           = (!r_dr_val || w_x_xfer) && !w_squash;
  assign F_squash        = w_squash;
  assign F_branch_target = r_dr_pc + t_addr'($signed(w_jimm));

  // Issue outputs straight from the decode register; idle slots read zero.
  always_comb begin
    X_val   = w_x_val;
    X_pc    = r_dr_pc;
    X_uop   = 4'd0;
    X_op1   = '0;
    X_op2   = '0;
    X_imm   = '0;
    X_waddr = 5'd0;
    X_wen   = 1'b0;
    if (r_dr_val) begin
      X_uop   = w_uop;
      X_op1   = w_is_jal ? t_data'(r_dr_pc) : w_rs1_val;
      X_op2   = w_is_jal ? t_data'(4) : w_rs2_val;
      X_imm   = w_imm;
      X_waddr = w_rd;
      X_wen   = w_wen;
    end
  end

  // Decode register: load on accept, drain on issue.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_dr_val  <= 1'b0;
      r_dr_inst <= '0;
      r_dr_pc   <= t_addr'(p_rst_pc);
    end else if (w_f_xfer) begin
      r_dr_val  <= 1'b1;
      r_dr_inst <= 32'(F_inst);
      r_dr_pc   <= F_pc;
    end else if (w_x_xfer) begin
      r_dr_val  <= 1'b0;
    end
  end

  // Scoreboard: writeback clears, issue sets; set wins on collision.
  always_ff @(posedge clk) begin
    if (rst)
      r_pend <= '0;
    else
      r_pend <= (w_pend_eff | w_pset) & ~32'd1;
  end

  // Register file: not reset, so late writebacks still land.
  always_ff @(posedge clk) begin
    if (W_val && (W_waddr != 5'd0))
      r_rf[W_waddr] <= W_wdata;
  end

endmodule

// File: tb/tb_decode_issue.sv
// tb_decode_issue: directed vectors with hand-computed expectations
// for decode_issue issue, stall, bypass, squash and reset.
module tb_decode_issue;

  logic        clk = 1'b0;
  logic        rst;
  logic        F_val;
  logic        F_rdy;
  logic [31:0] F_inst;
  logic [31:0] F_pc;
  logic        F_squash;
  logic [31:0] F_branch_target;
  logic        X_val;
  logic        X_rdy;
  logic [31:0] X_pc;
  logic [3:0]  X_uop;
  logic [31:0] X_op1;
  logic [31:0] X_op2;
  logic [31:0] X_imm;
  logic [4:0]  X_waddr;
  logic        X_wen;
  logic        W_val;
  logic [4:0]  W_waddr;
  logic [31:0] W_wdata;

  int n_vec = 0;
  int n_err = 0;

  localparam logic [31:0] I_ADDI1 = 32'h0050_0093;
  localparam logic [31:0] I_ADD2  = 32'h0010_8133;
  localparam logic [31:0] I_LW6   = 32'hFFC0_2303;
  localparam logic [31:0] I_MUL5  = 32'h0200_02B3;
  localparam logic [31:0] I_ADDI3 = 32'h0070_0193;
  localparam logic [31:0] I_LUI3  = 32'h1234_51B7;
  localparam logic [31:0] I_JAL1  = 32'h0200_00EF;
  localparam logic [31:0] I_ADD0  = 32'h0000_0033;
  localparam logic [31:0] I_ILL   = 32'hFFFF_FFFF;
  localparam logic [31:0] I_SW1   = 32'h0010_2423;

  decode_issue dut (
    .clk(clk), .rst(rst),
    .F_val(F_val), .F_rdy(F_rdy),
    .F_inst(F_inst), .F_pc(F_pc),
    .F_squash(F_squash),
    .F_branch_target(F_branch_target),
    .X_val(X_val), .X_rdy(X_rdy),
    .X_pc(X_pc), .X_uop(X_uop),
    .X_op1(X_op1), .X_op2(X_op2),
    .X_imm(X_imm), .X_waddr(X_waddr),
    .X_wen(X_wen),
    .W_val(W_val), .W_waddr(W_waddr),
    .W_wdata(W_wdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input logic [31:0] inst,
                       input logic [31:0] pc);
    F_val  = 1'b1;
    F_inst = inst;
    F_pc   = pc;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; F_val = 1'b0; F_inst = '0; F_pc = '0;
    X_rdy = 1'b1; W_val = 1'b0; W_waddr = '0; W_wdata = '0;
    step(); step();
    rst = 1'b0;
    #1;
    check("rst_xval", 32'(X_val), 0);
    check("rst_frdy", 32'(F_rdy), 1);
    check("rst_sq", 32'(F_squash), 0);
    check("rst_pc", X_pc, 0);
    check("rst_uop", 32'(X_uop), 0);
    check("rst_wen", 32'(X_wen), 0);

    // basic issue
    fetch(I_ADDI1, 32'h0);
    #1 check("t1_frdy", 32'(F_rdy), 1);
    step(); F_val = 1'b0; #1;
    check("t1_xval", 32'(X_val), 1);
    check("t1_uop", 32'(X_uop), 1);
    check("t1_op1", X_op1, 0);
    check("t1_imm", X_imm, 5);
    check("t1_wa", 32'(X_waddr), 1);
    check("t1_wen", 32'(X_wen), 1);
    step();
    check("t1_pend1", 32'(dut.r_pend[1]), 1);
    check("t1_idle", 32'(X_val), 0);

    // RAW stall then bypass issue
    fetch(I_ADD2, 32'h4);
    step(); F_val = 1'b0; #1;
    check("t3_stall0", 32'(X_val), 0);
    step();
    check("t3_stall1", 32'(X_val), 0);
    W_val = 1'b1; W_waddr = 5'd1; W_wdata = 32'h5;
    #1;
    check("t3_xval", 32'(X_val), 1);
    check("t3_uop", 32'(X_uop), 0);
    check("t3_op1", X_op1, 32'h5);
    check("t3_op2", X_op2, 32'h5);
    check("t3_wa", 32'(X_waddr), 2);
    step(); W_val = 1'b0; #1;
    check("t3_pend1", 32'(dut.r_pend[1]), 0);
    check("t3_pend2", 32'(dut.r_pend[2]), 1);

    // back-pressure
    X_rdy = 1'b0;
    fetch(I_LW6, 32'h8);
    step();
    fetch(I_MUL5, 32'hC);
    #1;
    check("t2_frdy0", 32'(F_rdy), 0);
    check("t2_xval", 32'(X_val), 1);
    check("t2_uop", 32'(X_uop), 3);
    check("t2_imm", X_imm, 32'hFFFF_FFFC);
    for (int i = 0; i < 2; i++) begin
      step();
      check("t2_hold_pc", X_pc, 32'h8);
      check("t2_hold_imm", X_imm, 32'hFFFF_FFFC);
      check("t2_hold_frdy", 32'(F_rdy), 0);
    end
    X_rdy = 1'b1;
    #1 check("t2_frdy1", 32'(F_rdy), 1);
    step(); F_val = 1'b0; #1;
    check("t2_mul_uop", 32'(X_uop), 2);
    check("t2_mul_pc", X_pc, 32'hC);
    check("t2_mul_wa", 32'(X_waddr), 5);
    check("t2_mul_val", 32'(X_val), 1);
    step();

    // WAW stall, same-cycle clear and set
    fetch(I_ADDI3, 32'h10);
    step();
    fetch(I_LUI3, 32'h14);
    #1 check("t4_frdy", 32'(F_rdy), 1);
    step(); F_val = 1'b0; #1;
    check("t4_stall0", 32'(X_val), 0);
    step();
    check("t4_stall1", 32'(X_val), 0);
    W_val = 1'b1; W_waddr = 5'd3; W_wdata = 32'h7;
    #1;
    check("t4_xval", 32'(X_val), 1);
    check("t4_uop", 32'(X_uop), 6);
    check("t4_imm", X_imm, 32'h1234_5000);
    step(); W_val = 1'b0; #1;
    check("t4_pend3", 32'(dut.r_pend[3]), 1);

    // JAL redirect
    fetch(I_JAL1, 32'h100);
    step();
    fetch(I_ADDI1, 32'h104);
    #1;
    check("t5_sq", 32'(F_squash), 1);
    check("t5_tgt", F_branch_target, 32'h120);
    check("t5_frdy", 32'(F_rdy), 0);
    check("t5_uop", 32'(X_uop), 5);
    check("t5_op1", X_op1, 32'h100);
    check("t5_op2", X_op2, 32'h4);
    check("t5_wen", 32'(X_wen), 1);
    step(); F_val = 1'b0; #1;
    check("t5_sq_off", 32'(F_squash), 0);
    check("t5_nowp", 32'(X_val), 0);

    // x0 destination and illegal encoding
    fetch(I_ADD0, 32'h200);
    step(); F_val = 1'b0; #1;
    check("t6_x0_val", 32'(X_val), 1);
    check("t6_x0_wen", 32'(X_wen), 0);
    step();
    check("t6_pend0", 32'(dut.r_pend[0]), 0);
    fetch(I_ILL, 32'h204);
    step(); F_val = 1'b0; #1;
    check("t6_ill_uop", 32'(X_uop), 15);
    check("t6_ill_wen", 32'(X_wen), 0);
    check("t6_ill_val", 32'(X_val), 1);
    step();

    // SW stalls on x1 (JAL pending), then reset mid-stall
    fetch(I_SW1, 32'h208);
    step(); F_val = 1'b0; #1;
    check("t6_sw_stall", 32'(X_val), 0);
    check("t6_sw_uop", 32'(X_uop), 4);
    check("t6_sw_imm", X_imm, 32'h8);
    check("t6_sw_wen", 32'(X_wen), 0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    check("t6_rst_val", 32'(X_val), 0);
    check("t6_rst_pend", dut.r_pend, 0);
    check("t6_rst_frdy", 32'(F_rdy), 1);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/decode_issue.md
Name: decode_issue

Overview:
- Decode/issue stage, directly downstream of the fetch unit.
- Consumes the F→D stream (val/rdy, inst, pc) and decodes an RV32 subset.
- Reads the internal 32x32 register file and tracks pending writes with a per-register scoreboard.
- Issues micro-ops to execute over a val/rdy interface. Resolves JAL in decode and drives squash/branch_target back to fetch.

Parameters:
- p_addr_bits, 32, PC/address width
- p_inst_bits, 32, instruction and data width
- p_rst_pc, 32'b0, unused-slot PC value presented on X_pc at reset

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- F_val  in  1  fetch presents instruction
- F_rdy  out  1  decode accepts instruction
- F_inst  in  32  instruction word
- F_pc  in  32  instruction PC
- F_squash  out  1  redirect fetch this cycle
- F_branch_target  out  32  redirect address, valid when F_squash=1
- X_val  out  1  micro-op valid to execute
- X_rdy  in  1  execute accepts
- X_pc  out  32  PC of issuing instruction
- X_uop  out  4  0=ADD 1=ADDI 2=MUL 3=LW 4=SW 5=JAL 6=LUI 15=ILLEGAL
- X_op1  out  32  rs1 value (JAL: pc)
- X_op2  out  32  rs2 value (JAL: 4)
- X_imm  out  32  sign-extended I/S imm, or U imm<<12
- X_waddr  out  5  destination register
- X_wen  out  1  instruction writes rd
- W_val  in  1  writeback valid
- W_waddr  in  5  writeback register
- W_wdata  in  32  writeback data

Behaviour:
- Clock and reset: one clock (clk); reset (rst) is synchronous, active-high.
- Decode register: one-entry DR (valid bit, inst, pc).
- Accept: F_rdy = !DR_val | x_xfer; F xfer = F_val & F_rdy loads DR. Otherwise DR_val clears on x_xfer.
- Decode is combinational from DR; X outputs are driven from DR, so there is no extra latency.
  - F xfer in cycle N → earliest X issue in cycle N+1.
- Operand read: rs1/rs2 read the regfile; x0 always reads 0.
  - Bypass: if W_val & W_waddr==rs & rs!=0, the operand is W_wdata in the same cycle.
- Hazard: hz = DR_val & ((uses_rs1 & pend[rs1]) | (uses_rs2 & pend[rs2]) | (X_wen & pend[rd])), where each pending bit is first cleared by a same-cycle W write.
  - Prevents RAW and WAW hazards.
  - Execute may retire out of order; at most one writer per register is in flight.
- Issue:
  - X_val = DR_val & !hz.
  - x_xfer = X_val & X_rdy.
  - X outputs must hold stable while X_val=1 and X_rdy=0.
- Scoreboard:
  - On W_val, pend[W_waddr] clears and regfile[W_waddr] is written (writes to x0 ignored).
  - On x_xfer & X_wen & rd!=0, pend[rd] sets; a set and a clear of the same register in the same cycle → set wins.
- Register usage by opcode:
  - ADD/MUL use rs1 and rs2.
  - ADDI/LW use rs1.
  - SW uses rs1 and rs2, X_wen=0.
  - LUI uses none.
  - JAL: X_wen=1, X_op1=pc, X_op2=4.
  - ILLEGAL (any other encoding): X_wen=0, issues normally.
  - rd=0 → X_wen=0.
- JAL redirect:
  - F_squash = x_xfer & uop==JAL; F_branch_target = DR_pc + sext(J-imm), 32-bit wrap.
  - In a squash cycle, F_rdy=0: the incoming F instruction is wrong-path and is not loaded.
  - Squash is asserted for exactly one cycle per JAL.
- Reset:
  - DR_val=0, all pend=0, X_val=0, F_squash=0, F_rdy=1, X_pc=p_rst_pc, other X outputs 0.
  - Regfile is not reset.
  - Reset mid-operation discards DR and clears the scoreboard; in-flight W writes after reset still update the regfile.
- Deadlock: none. A stall persists only until the matching W_val.

Test Plan:
1. Basic issue: ADDI x1,x0,5 with X_rdy=1 → next cycle X_val=1, uop=1, op1=0, imm=5, waddr=1, wen=1; pend[1]=1.
2. Back-pressure: X_rdy=0 for 3 cycles with a valid DR → F_rdy=0 and X outputs constant. Release → issue, and F_rdy=1 the same cycle.
3. RAW stall: ADDI x1, then ADD x2,x1,x1 → X_val=0 until W_val(x1, 0x5). In that W cycle, ADD issues with op1=op2=0x5 via bypass.
4. WAW stall: ADDI x3 pending, then LUI x3 → stalls until W_waddr=3. Same-cycle W clear and re-issue leaves pend[3]=1.
5. JAL at pc 0x100 with imm +0x20 → F_squash=1 for exactly one cycle, branch_target=0x120. The concurrent F instruction is not accepted; X op1=0x100, op2=4.
6. x0 and ILLEGAL: ADD x0,x0,x0 → wen=0, no pend. Encoding 0xFFFFFFFF → uop=15, wen=0. Reset mid-stall → X_val=0 and pend cleared on the next cycle.
